// File: rtl/sa_bitserial_driver.sv
// sa_bitserial_driver: host-side bit-serial driver for a compute subarray.
// Takes one parallel activation vector, streams it LSB-first one bit-plane
// per cycle, waits for the subarray done pulse, then holds the captured
// per-column ADC result on a valid/ready output until it is consumed.

module sa_bitserial_driver #(
    parameter int nSaRows        = 256,
    parameter int nSaCols        = 256,
    parameter int bitAdc         = 4,
    parameter int inputPrecision = 4
) (
    input  logic                                clk,
    input  logic                                nrst,
    input  logic                                act_valid_i,
    output logic                                act_ready_o,
    input  logic [nSaRows*inputPrecision-1:0]   act_i,
    output logic [nSaRows-1:0]                  bit_o,
    output logic                                bit_valid_o,
    output logic                                bit_last_o,
    input  logic [nSaCols*bitAdc-1:0]           sa_comp_i,
    input  logic                                sa_done_i,
    output logic                                res_valid_o,
    input  logic                                res_ready_i,
    output logic [nSaCols*bitAdc-1:0]           res_o,
    output logic                                busy_o
);

    // The counter must be able to hold inputPrecision itself, which marks
    // "all planes sent" and triggers the move to WAIT_DONE.
    localparam int CW = $clog2(inputPrecision + 1);
    localparam logic [CW-1:0] NUM_PLANES = CW'(inputPrecision);
    localparam logic [CW-1:0] LAST_PLANE = CW'(inputPrecision - 1);
    localparam logic [CW-1:0] ONE        = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_DONE,
        OUT
    } state_t;

    state_t                              state;
    state_t                              state_next;
    logic [CW-1:0]                       counter;
    logic [nSaRows*inputPrecision-1:0]   act_reg;
    logic [nSaRows-1:0]                  plane_first;
    logic [nSaRows-1:0]                  plane_cur;
    logic [inputPrecision-1:0]           row_bits;
    logic [inputPrecision-1:0]           row_shift;

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept, stream planes, wait for done, hand off result.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (act_valid_i)            state_next = SHIFT;
            SHIFT:     if (counter >= NUM_PLANES)  state_next = WAIT_DONE;
            WAIT_DONE: if (sa_done_i)              state_next = OUT;
            OUT:       if (res_ready_i)            state_next = IDLE;
            default:                               state_next = IDLE;
        endcase
    end

    // Plane extraction: plane 0 straight from the input for the accept edge,
    // and the plane selected by the counter from the latched activations.
    always_comb begin
        plane_first = '0;
        plane_cur   = '0;
        row_bits    = '0;
        row_shift   = '0;
        for (int r = 0; r < nSaRows; r++) begin
            plane_first[r] = act_i[r*inputPrecision];
            row_bits       = act_reg[r*inputPrecision +: inputPrecision];
            row_shift      = row_bits >> counter;
            plane_cur[r]   = row_shift[0];
        end
    end

    // Registered datapath: activation latch, plane counter, bit stream and
    // result capture, all updated according to the current state.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            counter     <= '0;
            act_reg     <= '0;
            bit_o       <= '0;
            bit_valid_o <= 1'b0;
            bit_last_o  <= 1'b0;
            res_o       <= '0;
            res_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (act_valid_i) begin
                        act_reg     <= act_i;
                        bit_o       <= plane_first;
                        bit_valid_o <= 1'b1;
                        bit_last_o  <= 1'b0;
                        counter     <= ONE;
                    end
                end
                SHIFT: begin
                    if (counter < NUM_PLANES) begin
                        bit_o       <= plane_cur;
                        bit_last_o  <= (counter == LAST_PLANE);
                        counter     <= counter + ONE;
                    end else begin
                        bit_o       <= '0;
                        bit_valid_o <= 1'b0;
                        bit_last_o  <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (sa_done_i) begin
                        res_o       <= sa_comp_i;
                        res_valid_o <= 1'b1;
                    end
                end
                OUT: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs decoded from state alone, so no input-to-ready path.
    always_comb begin
        act_ready_o = (state == IDLE);
        busy_o      = (state != IDLE);
    end

endmodule
